// File: rtl/data_nto1_arbiter.sv
// data_nto1_arbiter: merges P_CH_NUM framed source streams into one output stream, one whole frame at a time.
//
// Ports:
//   i_clk            rising-edge clock
//   i_rst            asynchronous active-low reset
//   i_data           per-channel data, channel k at [k*P_DATA_W +: P_DATA_W]
//   i_valid, i_last  per-channel beat valid / end-of-frame
//   i_len, i_type    per-channel frame header, stable while that channel is valid
//   o_ready          per-channel accept, only the granted channel can be ready
//   o_data, o_valid, o_last  registered merged stream
//   o_len, o_type    header of the frame in progress
//   i_out_ready      downstream accept
//   o_grant          one-hot owner of the current frame, zero when idle
//   o_nxt_frame_stop high whenever the arbiter is not idle
//
// Configuration macro:
//   ARB_FIXED_PRIO_EN  defined   -> fixed priority, channel 0 highest
//                      undefined -> round-robin starting after the last grant
module data_nto1_arbiter #(
    parameter int P_CH_NUM = 4,
    parameter int P_DATA_W = 8,
    parameter int P_LEN_W  = 16,
    parameter int P_TYPE_W = 16,
    parameter int P_GAP    = 2
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [P_CH_NUM*P_DATA_W-1:0] i_data,
    input  logic [P_CH_NUM-1:0]          i_valid,
    input  logic [P_CH_NUM-1:0]          i_last,
    input  logic [P_CH_NUM*P_LEN_W-1:0]  i_len,
    input  logic [P_CH_NUM*P_TYPE_W-1:0] i_type,
    output logic [P_CH_NUM-1:0]          o_ready,
    output logic [P_DATA_W-1:0]          o_data,
    output logic                         o_valid,
    output logic                         o_last,
    output logic [P_LEN_W-1:0]           o_len,
    output logic [P_TYPE_W-1:0]          o_type,
    input  logic                         i_out_ready,
    output logic [P_CH_NUM-1:0]          o_grant,
    output logic                         o_nxt_frame_stop
);
    localparam int IDX_W = $clog2(P_CH_NUM);
    localparam int CW    = IDX_W + 1;

    typedef enum logic [1:0] {IDLE, XFER, GAP} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   last_grant;
    logic [IDX_W-1:0]   pick;
    logic [3:0]         gap_cnt;
    logic               frame_done;
    logic               any_req;
    logic               slot_free;
    logic               accept;
    logic               last_retire;
    logic [P_DATA_W-1:0] cur_data;
    logic               cur_valid;
    logic               cur_last;

    assign any_req     = |i_valid;
    assign cur_data    = i_data[owner*P_DATA_W +: P_DATA_W];
    assign cur_valid   = i_valid[owner];
    assign cur_last    = i_last[owner];
    // The output register can take a beat when empty or when its beat leaves this cycle.
    assign slot_free   = !o_valid || i_out_ready;
    assign accept      = (state == XFER) && !frame_done && slot_free && cur_valid;
    assign last_retire = o_valid && o_last && i_out_ready;

`ifdef ARB_FIXED_PRIO_EN
    always_comb begin
        pick = '0;
        for (int i = P_CH_NUM - 1; i >= 0; i--)
            if (i_valid[i]) pick = IDX_W'(i);
    end
`else
    logic [CW-1:0] cand;

    // Walk the search order backwards so the earliest requester after last_grant is assigned last and wins.
    always_comb begin
        pick = '0;
        cand = '0;
        for (int i = P_CH_NUM - 1; i >= 0; i--) begin
            cand = {1'b0, last_grant} + CW'(i + 1);
            if (cand >= CW'(P_CH_NUM)) cand = cand - CW'(P_CH_NUM);
            if (i_valid[cand[IDX_W-1:0]]) pick = cand[IDX_W-1:0];
        end
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt        = state;
        o_ready          = '0;
        o_nxt_frame_stop = (state != IDLE);
        if (state == IDLE && any_req) state_nxt = XFER;
        if (state == XFER && last_retire) state_nxt = (P_GAP == 0) ? IDLE : GAP;
        if (state == GAP && gap_cnt == 4'(P_GAP - 1)) state_nxt = IDLE;
        // Acceptance stops once the last beat of the frame has been taken.
        if (state == XFER && !frame_done && slot_free) o_ready = o_grant;
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_data     <= '0;
            o_valid    <= 1'b0;
            o_last     <= 1'b0;
            o_len      <= '0;
            o_type     <= '0;
            o_grant    <= '0;
            owner      <= '0;
            last_grant <= IDX_W'(P_CH_NUM - 1);
            frame_done <= 1'b0;
            gap_cnt    <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                owner      <= pick;
                last_grant <= pick;
                o_grant    <= P_CH_NUM'(1) << pick;
                o_len      <= i_len[pick*P_LEN_W +: P_LEN_W];
                o_type     <= i_type[pick*P_TYPE_W +: P_TYPE_W];
                frame_done <= 1'b0;
            end else if (state == XFER && last_retire) begin
                o_grant <= '0;
            end
            if (accept) begin
                o_data  <= cur_data;
                o_valid <= 1'b1;
                o_last  <= cur_last;
                if (cur_last) frame_done <= 1'b1;
            end else if (i_out_ready) begin
                o_valid <= 1'b0;
                o_last  <= 1'b0;
            end
            gap_cnt <= (state == GAP) ? gap_cnt + 4'd1 : 4'd0;
        end
    end
endmodule

// File: tb/tb_data_nto1_arbiter.sv
// tb_data_nto1_arbiter: scoreboard bench for data_nto1_arbiter with a frame-level arbitration model.
`timescale 1ns/1ps
module tb_data_nto1_arbiter;
    localparam int N   = 4;
    localparam int W   = 8;
    localparam int LW  = 16;
    localparam int TW  = 16;
    localparam int GAP = 2;

    typedef struct packed {
        logic [W-1:0]  data;
        logic          last;
        logic          first;
        logic [LW-1:0] len;
        logic [TW-1:0] typ;
        logic [7:0]    ch;
    } beat_t;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic [N*W-1:0]  i_data;
    logic [N-1:0]    i_valid;
    logic [N-1:0]    i_last;
    logic [N*LW-1:0] i_len;
    logic [N*TW-1:0] i_type;
    logic [N-1:0]    o_ready;
    logic [W-1:0]    o_data;
    logic            o_valid;
    logic            o_last;
    logic [LW-1:0]   o_len;
    logic [TW-1:0]   o_type;
    logic            i_out_ready;
    logic [N-1:0]    o_grant;
    logic            o_nxt_frame_stop;

    beat_t q[N][$];
    beat_t mb[N][$];
    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    m_last = N - 1;
    bit    bp_mode = 0;
    bit    drop_en = 0;
    bit    stall_arm = 0;
    int    stall_left = 0;
    int    stall_seen = 0;
    logic [W-1:0] stall_val = '0;

    data_nto1_arbiter #(
        .P_CH_NUM(N), .P_DATA_W(W), .P_LEN_W(LW), .P_TYPE_W(TW), .P_GAP(GAP)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_data(i_data), .i_valid(i_valid),
        .i_last(i_last), .i_len(i_len), .i_type(i_type), .o_ready(o_ready),
        .o_data(o_data), .o_valid(o_valid), .o_last(o_last), .o_len(o_len),
        .o_type(o_type), .i_out_ready(i_out_ready), .o_grant(o_grant),
        .o_nxt_frame_stop(o_nxt_frame_stop)
    );

    initial forever #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not finish checks=%0d errors=%0d", checks, errors + 1);
        $fatal(1, "bench hung");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic add_frame(input int ch, input int n, input logic [LW-1:0] len,
                             input logic [TW-1:0] typ, input int dbase, input bit rnd);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data  = rnd ? W'($urandom) : W'(dbase + i);
            b.last  = (i == n - 1);
            b.first = (i == 0);
            b.len   = len;
            b.typ   = typ;
            b.ch    = 8'(ch);
            q[ch].push_back(b);
            mb[ch].push_back(b);
        end
    endtask

    // Every loaded frame is pending at every decision, so the order follows from the selection rule alone.
    task automatic plan();
        int    c;
        int    k;
        beat_t b;
        do begin
            c = -1;
`ifdef ARB_FIXED_PRIO_EN
            for (int i = N - 1; i >= 0; i--)
                if (mb[i].size() > 0) c = i;
`else
            for (int i = 0; i < N; i++) begin
                k = (m_last + 1 + i) % N;
                if (c < 0 && mb[k].size() > 0) c = k;
            end
`endif
            if (c >= 0) begin
                m_last = c;
                do begin
                    b = mb[c].pop_front();
                    exp_q.push_back(b);
                end while (!b.last);
            end
        end while (c >= 0);
    endtask

    task automatic flush();
        for (int k = 0; k < N; k++) begin
            q[k].delete();
            mb[k].delete();
        end
        exp_q.delete();
    endtask

    task automatic drain(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(negedge i_clk);
            #3;
            ok = (exp_q.size() == 0) && !o_nxt_frame_stop;
        end
        chk({"drain_", name}, 32'(ok), 32'd1);
        if (!ok) flush();
    endtask

    // Driver: inputs change at negedge, handshakes sampled 1ns later, consumed beats popped after posedge.
    initial begin : driver
        logic [N-1:0] fire;
        bit in_stall;
        i_valid = '0; i_last = '0; i_data = '0; i_len = '0; i_type = '0; i_out_ready = 1'b1;
        forever begin
            @(negedge i_clk);
            for (int k = 0; k < N; k++) begin
                if (q[k].size() > 0) begin
                    i_valid[k]           = q[k][0].first || !drop_en || ($urandom_range(0, 3) != 0);
                    i_data[k*W +: W]     = q[k][0].data;
                    i_last[k]            = q[k][0].last;
                    i_len[k*LW +: LW]    = q[k][0].len;
                    i_type[k*TW +: TW]   = q[k][0].typ;
                end else begin
                    i_valid[k] = 1'b0;
                    i_last[k]  = 1'b0;
                end
            end
            in_stall = 0;
            if (stall_left > 0) begin
                stall_left--;
                in_stall = 1;
            end else if (stall_arm && o_valid && o_data == stall_val) begin
                stall_arm  = 0;
                stall_left = 2;
                in_stall   = 1;
            end
            i_out_ready = in_stall ? 1'b0 : (bp_mode ? ($urandom_range(0, 3) != 0) : 1'b1);
            #1;
            fire = i_valid & o_ready;
            if (in_stall) begin
                stall_seen++;
                chk("stall_ready1", 32'(o_ready[1]), 32'd0);
                chk("stall_hold_data", 32'(o_data), 32'(stall_val));
                chk("stall_hold_valid", 32'(o_valid), 32'd1);
            end
            @(posedge i_clk);
            for (int k = 0; k < N; k++)
                if (fire[k] && q[k].size() > 0) void'(q[k].pop_front());
        end
    end

    // Monitor: scores every retired output beat and watches idle/ownership rules each cycle.
    initial begin : monitor
        beat_t e;
        int    idle_run;
        bit    seen_last;
        idle_run  = 0;
        seen_last = 0;
        forever begin
            @(negedge i_clk);
            #2;
            if (!i_rst) begin
                idle_run  = 0;
                seen_last = 0;
            end else begin
                chk("ready_outside_grant", 32'(o_ready & ~o_grant), 32'd0);
                if (!o_nxt_frame_stop) begin
                    chk("idle_grant", 32'(o_grant), 32'd0);
                    chk("idle_valid", 32'(o_valid), 32'd0);
                end
                if (o_valid) begin
                    if (seen_last) begin
                        chk("frame_gap_min", 32'(idle_run >= GAP), 32'd1);
                        seen_last = 0;
                    end
                    if (i_out_ready) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_beat data=%0h grant=%0h expected no beat", o_data, o_grant);
                        end else begin
                            e = exp_q.pop_front();
                            chk("out_data", 32'(o_data), 32'(e.data));
                            chk("out_last", 32'(o_last), 32'(e.last));
                            chk("out_len", 32'(o_len), 32'(e.len));
                            chk("out_type", 32'(o_type), 32'(e.typ));
                            chk("out_grant", 32'(o_grant), 32'd1 << e.ch);
                        end
                        if (o_last) begin
                            seen_last = 1;
                            idle_run  = 0;
                        end
                    end
                end else if (seen_last) begin
                    idle_run++;
                end
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 32'(o_valid), 32'd0);
        chk({tag, "_last"}, 32'(o_last), 32'd0);
        chk({tag, "_data"}, 32'(o_data), 32'd0);
        chk({tag, "_len"}, 32'(o_len), 32'd0);
        chk({tag, "_type"}, 32'(o_type), 32'd0);
        chk({tag, "_grant"}, 32'(o_grant), 32'd0);
        chk({tag, "_ready"}, 32'(o_ready), 32'd0);
        chk({tag, "_stop"}, 32'(o_nxt_frame_stop), 32'd0);
    endtask

    initial begin : main
        bit hit;
        int n;
        i_rst = 1'b0;
        repeat (3) @(negedge i_clk);
        #3;
        chk_all_zero("reset");
        @(negedge i_clk);
        i_rst  = 1'b1;
        m_last = N - 1;
        @(negedge i_clk);
        #3;

        // All channels requesting single-beat frames at once.
        for (int c = 0; c < N; c++)
            for (int j = 0; j < 2; j++)
                add_frame(c, 1, 16'd1, 16'h0100 + 16'(c), 8'h10 * c + j, 0);
        plan();
        drain("all_single");

        // Channels 0 and 2 with 4-beat frames and distinct headers.
        add_frame(0, 4, 16'd4, 16'h0800, 8'h00, 0);
        add_frame(2, 4, 16'd44, 16'h86dd, 8'h20, 0);
        plan();
        drain("ch0_ch2");

        // Channel 1 10-beat frame, downstream stalls 3 cycles while beat 5 is shown.
        stall_val  = 8'h54;
        stall_arm  = 1;
        stall_seen = 0;
        add_frame(1, 10, 16'd10, 16'h0a0a, 8'h50, 0);
        plan();
        drain("ch1_stall");
        chk("stall_cycles", 32'(stall_seen), 32'd3);
        stall_arm = 0;

        // Random frames with downstream backpressure and mid-frame valid drops.
        bp_mode = 1;
        drop_en = 1;
        repeat (20) begin
            for (int c = 0; c < N; c++) begin
                n = $urandom_range(0, 3);
                repeat (n) add_frame(c, $urandom_range(1, 6), LW'($urandom), TW'($urandom), 0, 1);
            end
            plan();
            drain("random");
        end
        bp_mode = 0;
        drop_en = 0;

        // Channel 3 frame aborted by reset at beat 3, then a fresh frame.
        add_frame(3, 6, 16'd6, 16'h3333, 8'h30, 0);
        plan();
        hit = 0;
        for (int i = 0; i < 200 && !hit; i++) begin
            @(negedge i_clk);
            #3;
            hit = o_valid && o_data == 8'h32;
        end
        chk("ch3_beat3_seen", 32'(hit), 32'd1);
        i_rst = 1'b0;
        #1;
        chk_all_zero("abort");
        flush();
        m_last = N - 1;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b1;
        #3;
        add_frame(3, 5, 16'd5, 16'h3c3c, 8'ha0, 0);
        plan();
        drain("ch3_fresh");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
